// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared register map, CTRL field positions, FSM states and hex font for ssd_scan_ctrl
package ssd_pkg;

    localparam logic [1:0] ADDR_DATA_LO = 2'd0;
    localparam logic [1:0] ADDR_DATA_HI = 2'd1;
    localparam logic [1:0] ADDR_CTRL    = 2'd2;
    localparam logic [1:0] ADDR_BLINK   = 2'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_BRIGHT_LSB = 4;
    localparam int CTRL_BLANK_LSB  = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    // Active-high segment patterns, bit0 = a ... bit6 = g
    localparam logic [6:0] FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// rtl/ssd_scan_ctrl_if.sv - APB register bus bundle for ssd_scan_ctrl
interface ssd_scan_ctrl_if;

    logic [15:0] PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [15:0] PWDATA;
    logic [15:0] PRDATA;
    logic        PREADY;

    modport master (
        output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        output PRDATA, PREADY
    );

endinterface

// File: rtl/ssd_hex_decode.sv
// rtl/ssd_hex_decode.sv - hex nibble to seven-segment lookup with optional active-low output
module ssd_hex_decode
    import ssd_pkg::*;
#(
    parameter bit INVERT = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Font lookup, flipped for common-anode style drive when INVERT is set
    always_comb begin
        seg = INVERT ? ~FONT[nibble] : FONT[nibble];
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - APB-programmed multiplexed seven-segment scanner; optional blink via SSD_BLINK_EN
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int DIV    = 50000,
    parameter bit INVERT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    ssd_scan_ctrl_if.slave    apb,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int               SUB     = DIV / 16;
    localparam int               SUBW    = (SUB > 1) ? $clog2(SUB) : 1;
    localparam logic [2:0]       LAST    = 3'(DIGITS - 1);
    localparam logic [6:0]       SEG_OFF = INVERT ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] AN_OFF = INVERT ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [DIGITS-1:0] AN_ONE = DIGITS'(1);

    logic        wr_en;
    logic [1:0]  reg_sel;
    logic [15:0] rd_data;
    logic        unused_addr;

    logic [15:0] data_lo;
    logic [7:0]  data_hi;
    logic        en_sh;
    logic [3:0]  bright_sh;
    logic [7:0]  blank_sh;

    logic [23:0] act_data;
    logic [3:0]  act_bright;
    logic [7:0]  act_blank;

    scan_state_t state_q, state_d;
    logic        scanning;
    logic        load_active;

    logic [SUBW-1:0] sub_cnt;
    logic [3:0]      subslot;
    logic [2:0]      digit;
    logic            slot_end;
    logic            frame_wrap;
    logic            blink_off;

    logic [31:0]       nib_src;
    logic [3:0]        nibble;
    logic [6:0]        dec_seg;
    logic              drive;
    logic [6:0]        seg_d;
    logic [DIGITS-1:0] an_d;

`ifdef SSD_BLINK_EN
    logic [7:0] blink_sh;
    logic [7:0] act_blink;
    logic [6:0] frame_cnt;
`endif

    assign wr_en       = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign reg_sel     = apb.PADDR[3:2];
    assign unused_addr = ^{apb.PADDR[15:4], apb.PADDR[1:0]};
    assign apb.PREADY  = apb.PSEL & apb.PENABLE;
    assign apb.PRDATA  = rd_data;

    // Shadow register writes on the APB access phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_lo   <= '0;
            data_hi   <= '0;
            en_sh     <= 1'b0;
            bright_sh <= '0;
            blank_sh  <= '0;
`ifdef SSD_BLINK_EN
            blink_sh  <= '0;
`endif
        end else if (wr_en) begin
            case (reg_sel)
                ADDR_DATA_LO: data_lo <= apb.PWDATA;
                ADDR_DATA_HI: data_hi <= apb.PWDATA[7:0];
                ADDR_CTRL: begin
                    en_sh     <= apb.PWDATA[CTRL_EN_BIT];
                    bright_sh <= apb.PWDATA[CTRL_BRIGHT_LSB +: 4];
                    blank_sh  <= apb.PWDATA[CTRL_BLANK_LSB +: 8];
                end
`ifdef SSD_BLINK_EN
                ADDR_BLINK: blink_sh <= apb.PWDATA[7:0];
`endif
                default: ;
            endcase
        end
    end

    // Read mux; unused fields and the absent BLINK register read as zero
    always_comb begin
        rd_data = 16'h0000;
        if (apb.PSEL && !apb.PWRITE) begin
            case (reg_sel)
                ADDR_DATA_LO: rd_data = data_lo;
                ADDR_DATA_HI: rd_data = {8'h00, data_hi};
                ADDR_CTRL:    rd_data = {blank_sh, bright_sh, 3'b000, en_sh};
`ifdef SSD_BLINK_EN
                ADDR_BLINK:   rd_data = {8'h00, blink_sh};
`endif
                default:      rd_data = 16'h0000;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: leave IDLE once enabled, drop back as soon as enable clears
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en_sh)  state_d = ST_SCAN;
            ST_SCAN: if (!en_sh) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Scanning stops the moment enable is cleared so the display blanks on the next edge
    assign scanning    = (state_q == ST_SCAN) && en_sh;
    assign slot_end    = (subslot == 4'hF) && (sub_cnt == SUBW'(SUB - 1));
    assign frame_wrap  = scanning && slot_end && (digit == LAST);
    assign load_active = ((state_q == ST_IDLE) && en_sh) || frame_wrap;

    // Slot prescaler (subslot:sub_cnt) and digit index; all held at zero when not scanning
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sub_cnt <= '0;
            subslot <= '0;
            digit   <= '0;
        end else if (!scanning) begin
            sub_cnt <= '0;
            subslot <= '0;
            digit   <= '0;
        end else begin
            if (sub_cnt == SUBW'(SUB - 1)) begin
                sub_cnt <= '0;
                subslot <= subslot + 4'd1;
            end else begin
                sub_cnt <= sub_cnt + SUBW'(1);
            end
            if (slot_end) digit <= (digit == LAST) ? 3'd0 : digit + 3'd1;
        end
    end

`ifdef SSD_BLINK_EN
    // Frame counter; bit 6 selects the blink-off half of each 128-frame period
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         frame_cnt <= '0;
        else if (!scanning) frame_cnt <= '0;
        else if (frame_wrap) frame_cnt <= frame_cnt + 7'd1;
    end
    assign blink_off = frame_cnt[6] & act_blink[digit];
`else
    assign blink_off = 1'b0;
`endif

    // Active copy only changes at enable or frame wrap so a frame is never mixed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_data   <= '0;
            act_bright <= '0;
            act_blank  <= '0;
`ifdef SSD_BLINK_EN
            act_blink  <= '0;
`endif
        end else if (load_active) begin
            act_data   <= {data_hi, data_lo};
            act_bright <= bright_sh;
            act_blank  <= blank_sh;
`ifdef SSD_BLINK_EN
            act_blink  <= blink_sh;
`endif
        end
    end

    // Digit select, brightness gating and masking ahead of the output register
    always_comb begin
        nib_src = {8'h00, act_data};
        nibble  = nib_src[{digit, 2'b00} +: 4];
        drive   = scanning && (subslot <= act_bright) && !act_blank[digit] && !blink_off;
        seg_d   = drive ? dec_seg : SEG_OFF;
        an_d    = drive ? (AN_ONE << digit) : '0;
    end

    ssd_hex_decode #(.INVERT(INVERT)) u_hex_decode (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    // seg and an registered together so they switch on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= seg_d;
            an  <= INVERT ? ~an_d : an_d;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb/tb_ssd_scan_ctrl.sv - directed self-checking bench for ssd_scan_ctrl (DIV=32, DIGITS=6, INVERT=0)
module tb_ssd_scan_ctrl;

    localparam logic [6:0] FONT_TB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct {
        string       name;
        logic [15:0] waddr;
        logic [15:0] wdata;
        logic [15:0] raddr;
        logic [15:0] exp;
    } reg_vec_t;

    logic       clk;
    logic       reset;
    logic [6:0] seg;
    logic [5:0] an;
    int         n_cmp;
    int         n_err;
    reg_vec_t   vecs [6];
    logic [15:0] rd;
    logic        rdy;

    ssd_scan_ctrl_if bus ();

    ssd_scan_ctrl #(.DIGITS(6), .DIV(32), .INVERT(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .apb   (bus),
        .seg   (seg),
        .an    (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [15:0] addr, input logic [15:0] data);
        @(posedge clk); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = addr; bus.PWDATA = data;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        @(posedge clk); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] addr, output logic [15:0] data, output logic ready);
        @(posedge clk); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = addr;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        #3;
        data  = bus.PRDATA;
        ready = bus.PREADY;
        @(posedge clk); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic load_digits(input logic [15:0] lo, input logic [15:0] hi, input logic [15:0] ctrl);
        apb_write(16'h0, lo);
        apb_write(16'h4, hi);
        apb_write(16'h8, ctrl);
    endtask

    // Expected display: output lags the enabling CTRL write by two edges, 32-clock slots, 2-clock subslots
    task automatic run_scan(input int ncyc, input logic [3:0] bright, input logic [7:0] blank,
                            input logic [23:0] d0, input logic [23:0] d1);
        for (int k = 0; k < ncyc; k++) begin
            logic [23:0] d;
            int          p;
            int          dig;
            logic [5:0]  ea;
            logic [6:0]  es;
            @(negedge clk);
            ea = '0;
            es = '0;
            if (k >= 2) begin
                p   = k - 2;
                dig = (p / 32) % 6;
                d   = (p / 192 == 0) ? d0 : d1;
                if (((p % 32) / 2) <= int'(bright) && !blank[dig]) begin
                    ea = 6'(1) << dig;
                    es = FONT_TB[d[dig*4 +: 4]];
                end
            end
            check($sformatf("scan_an k=%0d", k), 32'(an), 32'(ea));
            check($sformatf("scan_seg k=%0d", k), 32'(seg), 32'(es));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.PADDR = '0; bus.PWRITE = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWDATA = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        @(negedge clk);
        check("rst_an", 32'(an), 32'h0);
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_pready", 32'(bus.PREADY), 32'h0);
        for (int a = 0; a < 4; a++) begin
            apb_read(16'(a * 4), rd, rdy);
            check($sformatf("rst_reg%0d", a), 32'(rd), 32'h0);
        end

        vecs[0] = '{"data_lo",   16'h0000, 16'h1234, 16'h0000, 16'h1234};
        vecs[1] = '{"data_hi",   16'h0004, 16'hABCD, 16'h0004, 16'h00CD};
        vecs[2] = '{"ctrl",      16'h0008, 16'hFFFE, 16'h0008, 16'hFFF0};
`ifdef SSD_BLINK_EN
        vecs[3] = '{"blink",     16'h000C, 16'h00FF, 16'h000C, 16'h00FF};
`else
        vecs[3] = '{"blink",     16'h000C, 16'h00FF, 16'h000C, 16'h0000};
`endif
        vecs[4] = '{"alias_lo",  16'h0010, 16'h5555, 16'h0000, 16'h5555};
        vecs[5] = '{"hi_lowbit", 16'h0004, 16'h0012, 16'h0007, 16'h0012};
        for (int i = 0; i < 6; i++) begin
            apb_write(vecs[i].waddr, vecs[i].wdata);
            apb_read(vecs[i].raddr, rd, rdy);
            check({"rd_", vecs[i].name}, 32'(rd), 32'(vecs[i].exp));
            check({"pready_", vecs[i].name}, 32'(rdy), 32'h1);
        end
        @(negedge clk);
        check("idle_an", 32'(an), 32'h0);
        check("idle_seg", 32'(seg), 32'h0);

        do_reset();
        load_digits(16'h3210, 16'h0054, 16'h00F1);
        run_scan(200, 4'hF, 8'h00, 24'h543210, 24'h543210);

        do_reset();
        load_digits(16'h3210, 16'h0054, 16'h0031);
        run_scan(200, 4'h3, 8'h00, 24'h543210, 24'h543210);

        do_reset();
        load_digits(16'h3210, 16'h0054, 16'h04F1);
        run_scan(200, 4'hF, 8'h04, 24'h543210, 24'h543210);

        do_reset();
        load_digits(16'h3210, 16'h0054, 16'h00F1);
        fork
            run_scan(390, 4'hF, 8'h00, 24'h543210, 24'h54AAAA);
            begin
                logic [15:0] rb;
                logic        rr;
                repeat (70) @(negedge clk);
                apb_write(16'h0, 16'hAAAA);
                apb_read(16'h0, rb, rr);
                check("midframe_readback", 32'(rb), 32'hAAAA);
            end
        join

        do_reset();
        load_digits(16'h3210, 16'h0054, 16'h00F1);
        repeat (40) @(negedge clk);
        apb_write(16'h8, 16'h00F0);
        @(negedge clk);
        check("disable_an_before", 32'(an != 6'h0), 32'h1);
        @(negedge clk);
        check("disable_an_after", 32'(an), 32'h0);
        check("disable_seg_after", 32'(seg), 32'h0);
        apb_read(16'h8, rd, rdy);
        check("disable_ctrl_rd", 32'(rd), 32'h00F0);
        apb_write(16'h8, 16'h00F1);
        run_scan(40, 4'hF, 8'h00, 24'h543210, 24'h543210);

        do_reset();
        load_digits(16'h3210, 16'h0054, 16'h00F1);
        repeat (50) @(negedge clk);
        check("pre_rst_an", 32'(an), 32'h2);
        #2 reset = 1'b0;
        #1;
        check("async_rst_an", 32'(an), 32'h0);
        check("async_rst_seg", 32'(seg), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int a = 0; a < 4; a++) begin
            apb_read(16'(a * 4), rd, rdy);
            check($sformatf("post_rst_reg%0d", a), 32'(rd), 32'h0);
        end

        do_reset();
        apb_write(16'hC, 16'h0001);
        apb_read(16'hC, rd, rdy);
`ifdef SSD_BLINK_EN
        check("blink_rd", 32'(rd), 32'h0001);
`else
        check("blink_rd", 32'(rd), 32'h0000);
`endif
        load_digits(16'h3210, 16'h0054, 16'h00F1);
        repeat (63 * 192 + 13) @(negedge clk);
        check("blink_frame63_d0", 32'(an), 32'h1);
        repeat (192) @(negedge clk);
`ifdef SSD_BLINK_EN
        check("blink_frame64_d0", 32'(an), 32'h0);
`else
        check("blink_frame64_d0", 32'(an), 32'h1);
`endif
        repeat (30) @(negedge clk);
        check("blink_frame64_d1", 32'(an), 32'h2);
        check("blink_frame64_seg1", 32'(seg), 32'h06);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
